// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes and FSM state type for the iterative
// multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the execute stage (master)
// and the multiply/divide unit (slave).
//   start, op, A, B : request, sampled on the rising clock edge
//   busy, done      : unit status, both registered
//   hi, lo          : architectural HI/LO registers
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_datapath.sv
// mdu_datapath: operand magnitudes, 2*WIDTH accumulator, one-bit-per-cycle
// shift-add multiply / restoring divide step, and combinational sign fix-up.
//   load       : capture |A|, |B| and sign flags, clear the accumulator
//   step       : advance one multiply or divide iteration
//   is_div     : divide when set (sampled with load)
//   is_signed  : treat operands as two's complement (sampled with load)
//   res_hi/lo  : signed-corrected result, valid once all steps are done
module mdu_datapath #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               div_q, div_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, mul_add;
  logic [WIDTH:0]     sum, r_shift, diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    a_neg = is_signed & a_in[WIDTH-1];
    b_neg = is_signed & b_in[WIDTH-1];
    a_mag = a_neg ? -a_in : a_in;
    b_mag = b_neg ? -b_in : b_in;

    // multiply: add multiplicand into the upper half, shift everything right
    mul_add = b_q[0] ? a_q : '0;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

    // divide: bring in the next dividend bit, keep the difference if no borrow
    r_shift  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    diff     = r_shift - {1'b0, b_q};
    qbit     = ~diff[WIDTH];
    rem_next = qbit ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];

    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    div_d     = div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;

    if (load) begin
      acc_d     = '0;
      a_d       = a_mag;
      b_d       = b_mag;
      div_d     = is_div;
      // a zero divisor must leave the all-ones quotient untouched
      res_neg_d = (a_neg ^ b_neg) & (b_in != '0);
      rem_neg_d = a_neg;
    end else if (step) begin
      if (div_q) begin
        acc_d = {rem_next, acc_q[WIDTH-2:0], qbit};
        a_d   = a_q << 1;
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        b_d   = b_q >> 1;
      end
    end

    prod_fix = res_neg_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      res_lo = res_neg_q ? -quo : quo;
      res_hi = rem_neg_q ? -rem : rem;
    end else begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      div_q     <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      div_q     <= div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mdu_iter_if slave (start/op/A/B in, busy/done/hi/lo out)
//
// state | meaning
// IDLE  | accepts start; mthi/mtlo write HI/LO directly
// RUN   | one multiply/divide step per cycle, WIDTH cycles (down-counter)
// FIX   | sign-corrected result written to HI/LO, done pulsed
module mdu_iter
  import mdu_pkg::*;
#(parameter int WIDTH = 32) (
  input logic        clk,
  input logic        reset,
  mdu_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             dp_load, dp_step;
  logic [WIDTH-1:0] res_hi, res_lo;

  mdu_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (dp_load),
    .step      (dp_step),
    .is_div    (bus.op[1]),
    .is_signed (bus.op[0]),
    .a_in      (bus.A),
    .b_in      (bus.B),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dp_load = 1'b0;
    dp_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
              dp_load = 1'b1;
              cnt_d   = CW'(WIDTH);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
